// File: rtl/mac_stream_engine.sv
// mac_stream_engine: LANES parallel multiply-accumulate dot products over a valid/ready
// operand stream, with optional signed operands, saturation and sticky per-lane overflow.
`default_nettype none

module mac_stream_engine #(
  parameter int DWIDTH = 32,
  parameter int LANES  = 4,
  parameter int AWIDTH = 80,
  parameter int LWIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [LWIDTH-1:0]        len_i,
  input  logic                     signed_mode_i,
  input  logic                     sat_mode_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [LANES*DWIDTH-1:0]  s_a_i,
  input  logic [LANES*DWIDTH-1:0]  s_b_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [LANES*AWIDTH-1:0]  m_data_o,
  output logic [LANES-1:0]         ovf_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [LWIDTH-1:0] len_q, cnt_q, cnt_d;
  logic              signed_q, sat_q, prod_vld_q, done_q;
  logic              start_acc, beat_acc, last_beat;
  logic              s_ready, m_valid;

  assign start_acc = (state_q == IDLE) && start_i;
  assign beat_acc  = s_ready && s_valid_i;
  assign cnt_d     = cnt_q + 1'b1;
  assign last_beat = beat_acc && (cnt_d == len_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // DRAIN waits until the product pipeline is empty, so the final sum is settled in HOLD.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    unique case (state_q)
      IDLE:  if (start_i) state_d = (len_i == '0) ? HOLD : ACCUM;
      ACCUM: begin
        s_ready = 1'b1;
        if (last_beat) state_d = DRAIN;
      end
      DRAIN: if (!prod_vld_q) state_d = HOLD;
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q      <= '0;
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      sat_q      <= 1'b0;
      prod_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      prod_vld_q <= beat_acc;
      done_q     <= (state_q == HOLD) && m_ready_i;
      if (start_acc) begin
        len_q    <= len_i;
        signed_q <= signed_mode_i;
        sat_q    <= sat_mode_i;
        cnt_q    <= '0;
      end else if (beat_acc) begin
        cnt_q <= cnt_d;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DWIDTH-1:0]          a, b;
    logic signed [2*DWIDTH-1:0] sprod;
    logic [2*DWIDTH-1:0]        uprod, prod_q;
    logic [AWIDTH-1:0]          ext, acc_q, acc_d;
    logic [AWIDTH:0]            sum;
    logic                       ovf_q, of;

    assign a     = s_a_i[i*DWIDTH +: DWIDTH];
    assign b     = s_b_i[i*DWIDTH +: DWIDTH];
    assign sprod = $signed({{DWIDTH{a[DWIDTH-1]}}, a}) * $signed({{DWIDTH{b[DWIDTH-1]}}, b});
    assign uprod = {{DWIDTH{1'b0}}, a} * {{DWIDTH{1'b0}}, b};
    assign ext   = signed_q ? AWIDTH'($signed(prod_q)) : AWIDTH'(prod_q);

    // One guard bit above the accumulator exposes overflow in either number system.
    always_comb begin
      sum   = signed_q ? ({acc_q[AWIDTH-1], acc_q} + {ext[AWIDTH-1], ext})
                       : ({1'b0, acc_q} + {1'b0, ext});
      of    = signed_q ? (sum[AWIDTH] != sum[AWIDTH-1]) : sum[AWIDTH];
      acc_d = sum[AWIDTH-1:0];
      if (of && sat_q) begin
        if (!signed_q)       acc_d = '1;
        else if (sum[AWIDTH]) acc_d = {1'b1, {(AWIDTH-1){1'b0}}};
        else                 acc_d = {1'b0, {(AWIDTH-1){1'b1}}};
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        prod_q <= '0;
        acc_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (beat_acc) prod_q <= signed_q ? sprod : uprod;
        if (start_acc) begin
          acc_q <= '0;
          ovf_q <= 1'b0;
        end else if (prod_vld_q) begin
          acc_q <= acc_d;
          ovf_q <= ovf_q | of;
        end
      end
    end

    assign m_data_o[i*AWIDTH +: AWIDTH] = acc_q;
    assign ovf_o[i]                     = ovf_q;
  end

  assign s_ready_o = s_ready;
  assign m_valid_o = m_valid;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;

endmodule

`default_nettype wire
